ddr_app_bridge: RTL and testbench
=================================

Name: ddr_app_bridge

Overview:
- Request-level front end for the Gowin DDR3 controller user ("app_") interface.
- Sits between a traffic source (tester, DMA or CPU cache-line port) and the controller.
- Converts one accepted burst request (write or read, 1–64 beats of 128 bits) into the controller's command, write-data and read-data handshakes.
- Returns read beats with a last flag, pulses write completion, and flags a stalled controller via a timeout.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles without progress in a busy state before aborting with err_timeout.
- ADDR_W, 28: width of req_addr and app_addr.

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- init_calib_complete  in  1  controller calibration done
- req_valid  in  1  request present
- req_ready  out  1  bridge accepts request this cycle
- req_we  in  1  1=write, 0=read
- req_addr  in  ADDR_W  burst start address {bank,row,col}
- req_len  in  6  beats minus one (0..63)
- wd_valid  in  1  upstream write beat present
- wd_ready  out  1  write beat consumed this cycle
- wd_data  in  128  write beat
- wr_done  out  1  one-cycle pulse: write burst fully handed to controller
- rd_valid  out  1  read beat valid (no backpressure)
- rd_data  out  128  read beat
- rd_last  out  1  final beat of read burst
- busy  out  1  state != IDLE
- err_timeout  out  1  sticky timeout flag
- app_cmd_en  out  1  command strobe
- app_cmd  out  3  0=write, 1=read
- app_addr  out  ADDR_W  command address
- app_burst_number  out  6  beats minus one
- app_cmd_rdy  in  1  controller accepts command
- app_wdata_en  out  1  write beat strobe
- app_wdata_end  out  1  equal to app_wdata_en (1 beat = 1 transfer)
- app_wdata  out  128  write beat
- app_wdata_rdy  in  1  controller accepts write data
- app_rdata_valid  in  1  read beat valid
- app_rdata_end  in  1  unused, ignored
- app_rdata  in  128  read beat

Behaviour:
- Reset: state IDLE; all registered outputs 0, including app_addr, app_cmd, app_burst_number, rd_data, wr_done, rd_valid, rd_last and err_timeout. Beat counters, cmd_sent flag and timeout counter cleared. Reset mid-burst abandons the burst silently; no wr_done or rd_last is produced.
- States: IDLE, WR, RD.
- IDLE:
  - req_ready = init_calib_complete && !err_timeout (combinational).
  - On req_valid && req_ready: latch app_addr <= req_addr, app_burst_number <= req_len, app_cmd <= req_we ? 0 : 1; beat_cnt <= req_len+1 (7-bit); cmd_sent <= 0; go to WR or RD.
- Command issue (WR and RD):
  - app_cmd_en = !cmd_sent && app_cmd_rdy (combinational); the command is transferred in that cycle.
  - cmd_sent <= 1 in the same cycle.
  - Exactly one command per request.
- WR:
  - wd_ready = (beat_cnt != 0) && app_wdata_rdy.
  - app_wdata_en = app_wdata_end = wd_valid && wd_ready.
  - app_wdata = wd_data (pass-through).
  - Each transfer decrements beat_cnt.
  - Data beats may precede, coincide with, or follow the command.
  - When cmd_sent and beat_cnt==0 (both registered): wr_done=1 for one cycle, go to IDLE.
- RD:
  - Beats are counted only after cmd_sent.
  - On app_rdata_valid: next cycle rd_valid=1, rd_data=app_rdata, rd_last=(beat_cnt==1), beat_cnt decrements.
  - On the final beat go to IDLE; rd_valid/rd_last for that beat appear in the first IDLE cycle.
  - Latency is 1 cycle from app_rdata_valid to rd_valid.
- app_rdata_valid in IDLE or WR, or before cmd_sent: ignored (no rd_valid).
- Timeout:
  - 16-bit counter cleared on entry to WR/RD and on any progress (command transfer, write beat, read beat).
  - Increments otherwise while busy.
  - On reaching TIMEOUT_CYCLES-1: err_timeout<=1, go to IDLE, no wr_done or rd_last.
  - err_timeout clears only on rst; while set, req_ready=0.
- busy = (state != IDLE), registered from state.
- A new request cannot be accepted in the same cycle as wr_done or the last read beat; the earliest accept is the following cycle.

Test Plan:
- Calib gating: init_calib_complete=0, req_valid=1 -> req_ready=0 and no app_cmd_en for 100 cycles; raise calib -> request accepted next cycle.
- 4-beat write: req_we=1, addr=0, len=3, data 0x0123_4567_890A_BCDE_FEDC_BA98_7654_3210 +k, rdy always 1 -> one app_cmd_en with cmd=0, burst=3; 4 app_wdata_en pulses with matching data; wr_done exactly once.
- Write stalls: app_cmd_rdy low 5 cycles, app_wdata_rdy toggling 1/0 -> still exactly 1 command and 4 beats in order; wr_done only after both complete.
- 4-beat read: len=3, controller returns beats D0..D3 with gaps -> 4 rd_valid pulses, each 1 cycle after app_rdata_valid, with data D0..D3; rd_last only with D3; a stray app_rdata_valid in IDLE gives no rd_valid.
- Timeout: read issued, no rdata, TIMEOUT_CYCLES=16 -> err_timeout=1 on cycle 16 after the last progress, state IDLE, req_ready held 0 until rst.
- Reset mid-write after 2 of 4 beats -> next cycle all outputs 0, no wr_done; a subsequent request behaves normally.

Source files
------------

// File: rtl/ddr_app_bridge.sv
// ddr_app_bridge: request-level front end for the DDR3 controller app_ interface.
// One accepted burst request (1..64 beats of 128 bits) becomes exactly one
// controller command plus the matching write-data or read-data handshakes.
// A stalled controller is caught by a progress timeout that leaves the bridge
// locked out (err_timeout) until reset.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for a request; req_ready while calibrated and no error
// ST_WR   | write burst: issue command, stream beats, pulse wr_done
// ST_RD   | read burst: issue command, forward beats with rd_last
module ddr_app_bridge #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ADDR_W         = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_calib_complete,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [5:0]        req_len,

    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [127:0]      wd_data,
    output logic              wr_done,

    output logic              rd_valid,
    output logic [127:0]      rd_data,
    output logic              rd_last,

    output logic              busy,
    output logic              err_timeout,

    output logic              app_cmd_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    output logic [5:0]        app_burst_number,
    input  logic              app_cmd_rdy,
    output logic              app_wdata_en,
    output logic              app_wdata_end,
    output logic [127:0]      app_wdata,
    input  logic              app_wdata_rdy,
    input  logic              app_rdata_valid,
    input  logic              app_rdata_end,
    input  logic [127:0]      app_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_t;

    // Terminal count of the progress timer; the abort fires on the cycle after it.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [6:0]  beat_cnt;
    logic        cmd_sent;
    logic [15:0] tmo_cnt;

    logic        accept;
    logic        wr_xfer;
    logic        rd_beat;
    logic        progress;
    logic        tmo_hit;

    // app_rdata_end carries no extra information: one beat is one transfer.
    logic        unused_rdata_end;
    assign unused_rdata_end = app_rdata_end;

    // Write data is a straight pass-through; the strobe is the handshake itself.
    assign app_wdata     = wd_data;
    assign app_wdata_en  = wr_xfer;
    assign app_wdata_end = wr_xfer;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs; wr_done is decoded from registered
    // state so it can never coincide with an accept.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        wd_ready   = 1'b0;
        app_cmd_en = 1'b0;
        wr_done    = 1'b0;
        accept     = 1'b0;
        wr_xfer    = 1'b0;
        rd_beat    = 1'b0;
        progress   = 1'b0;
        tmo_hit    = 1'b0;

        case (state)
            ST_IDLE: begin
                req_ready = init_calib_complete && !err_timeout;
                accept    = req_valid && req_ready;
                if (accept) begin
                    state_nxt = req_we ? ST_WR : ST_RD;
                end
            end

            ST_WR: begin
                app_cmd_en = !cmd_sent && app_cmd_rdy;
                wd_ready   = (beat_cnt != 7'd0) && app_wdata_rdy;
                wr_xfer    = wd_valid && wd_ready;
                progress   = app_cmd_en || wr_xfer;
                if (cmd_sent && (beat_cnt == 7'd0)) begin
                    wr_done   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (!progress && (tmo_cnt == TMO_LAST)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end

            ST_RD: begin
                app_cmd_en = !cmd_sent && app_cmd_rdy;
                // Beats before the command has gone out cannot belong to this burst.
                rd_beat    = cmd_sent && app_rdata_valid;
                progress   = app_cmd_en || rd_beat;
                if (rd_beat && (beat_cnt == 7'd1)) begin
                    state_nxt = ST_IDLE;
                end else if (!progress && (tmo_cnt == TMO_LAST)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch the command fields for the whole burst when a request is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            app_addr         <= '0;
            app_burst_number <= '0;
            app_cmd          <= '0;
        end else if (accept) begin
            app_addr         <= req_addr;
            app_burst_number <= req_len;
            app_cmd          <= req_we ? 3'd0 : 3'd1;
        end
    end

    // Beat counter and one-command-per-request flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            cmd_sent <= 1'b0;
        end else begin
            if (accept) begin
                beat_cnt <= {1'b0, req_len} + 7'd1;
                cmd_sent <= 1'b0;
            end else begin
                if (wr_xfer || rd_beat) begin
                    beat_cnt <= beat_cnt - 7'd1;
                end
                if (app_cmd_en) begin
                    cmd_sent <= 1'b1;
                end
            end
        end
    end

    // Register read beats toward the source; rd_last marks the final one.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_beat;
            rd_last  <= rd_beat && (beat_cnt == 7'd1);
            if (rd_beat) begin
                rd_data <= app_rdata;
            end
        end
    end

    // Progress timer: restarts on any handshake, sticky error on expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            if ((state == ST_IDLE) || progress || (state_nxt == ST_IDLE)) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
            if (tmo_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end

    // busy mirrors the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_ddr_app_bridge.sv
// Directed bench for ddr_app_bridge: calibration gating, plain and stalled
// writes, gapped reads, timeout lock-out and reset in the middle of a burst.
module tb_ddr_app_bridge;

    localparam int ADDR_W = 28;
    localparam int TMO    = 16;
    localparam logic [127:0] WBASE = 128'h0123_4567_890A_BCDE_FEDC_BA98_7654_3210;

    logic              clk = 1'b0;
    logic              rst;
    logic              init_calib_complete;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [5:0]        req_len;
    logic              wd_valid;
    logic              wd_ready;
    logic [127:0]      wd_data;
    logic              wr_done;
    logic              rd_valid;
    logic [127:0]      rd_data;
    logic              rd_last;
    logic              busy;
    logic              err_timeout;
    logic              app_cmd_en;
    logic [2:0]        app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic [5:0]        app_burst_number;
    logic              app_cmd_rdy;
    logic              app_wdata_en;
    logic              app_wdata_end;
    logic [127:0]      app_wdata;
    logic              app_wdata_rdy;
    logic              app_rdata_valid;
    logic              app_rdata_end;
    logic [127:0]      app_rdata;

    ddr_app_bridge #(.TIMEOUT_CYCLES(TMO), .ADDR_W(ADDR_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .init_calib_complete (init_calib_complete),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_we              (req_we),
        .req_addr            (req_addr),
        .req_len             (req_len),
        .wd_valid            (wd_valid),
        .wd_ready            (wd_ready),
        .wd_data             (wd_data),
        .wr_done             (wr_done),
        .rd_valid            (rd_valid),
        .rd_data             (rd_data),
        .rd_last             (rd_last),
        .busy                (busy),
        .err_timeout         (err_timeout),
        .app_cmd_en          (app_cmd_en),
        .app_cmd             (app_cmd),
        .app_addr            (app_addr),
        .app_burst_number    (app_burst_number),
        .app_cmd_rdy         (app_cmd_rdy),
        .app_wdata_en        (app_wdata_en),
        .app_wdata_end       (app_wdata_end),
        .app_wdata           (app_wdata),
        .app_wdata_rdy       (app_wdata_rdy),
        .app_rdata_valid     (app_rdata_valid),
        .app_rdata_end       (app_rdata_end),
        .app_rdata           (app_rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // monitor state, updated once per cycle at the falling edge
    int                cmd_n, wr_n, rd_n, done_n;
    int                done_cmd_n, done_wr_n;
    logic              rdy_seen, rdy_at_done;
    logic [2:0]        last_cmd;
    logic [ADDR_W-1:0] last_addr;
    logic [5:0]        last_burst;
    logic [127:0]      wr_log [8];
    logic [127:0]      rd_log [8];
    logic [7:0]        rd_last_log;
    logic              lat_on, rd_armed, pend, adv;
    logic [127:0]      wbase;
    int                wd_k;
    logic [127:0]      rdat [4];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        cmd_n = 0; wr_n = 0; rd_n = 0; done_n = 0;
        done_cmd_n = 0; done_wr_n = 0;
        rdy_seen = 1'b0; rdy_at_done = 1'b0;
        last_cmd = '0; last_addr = '0; last_burst = '0;
        rd_last_log = '0;
        lat_on = 1'b0; rd_armed = 1'b0; pend = 1'b0; adv = 1'b0;
        wd_k = 0;
        wd_data = wbase;
    endtask

    task automatic sample();
        if (lat_on) chk("rd_latency", {127'd0, rd_valid}, {127'd0, pend});
        pend = app_rdata_valid && rd_armed;
        if (req_ready) rdy_seen = 1'b1;
        if (app_cmd_en) begin
            cmd_n++;
            last_cmd   = app_cmd;
            last_addr  = app_addr;
            last_burst = app_burst_number;
        end
        adv = 1'b0;
        if (app_wdata_en) begin
            chk("wdata_end", {127'd0, app_wdata_end}, 128'd1);
            if (wr_n < 8) wr_log[wr_n] = app_wdata;
            wr_n++;
            adv = 1'b1;
        end
        if (wr_done) begin
            done_n++;
            done_cmd_n  = cmd_n;
            done_wr_n   = wr_n;
            rdy_at_done = req_ready;
        end
        if (rd_valid) begin
            if (rd_n < 8) begin
                rd_log[rd_n]      = rd_data;
                rd_last_log[rd_n] = rd_last;
            end
            rd_n++;
        end
    endtask

    // one clock: observe at the falling edge, advance the write source after the rising edge
    task automatic cyc();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        if (adv) begin
            wd_k++;
            wd_data = wbase + 128'(wd_k);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic wait_done(input int lim, input string tag);
        for (int i = 0; i < lim && done_n == 0; i++) cyc();
        chk(tag, 128'(done_n), 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        init_calib_complete = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
        wd_valid = 1'b0; wd_data = '0;
        app_cmd_rdy = 1'b1; app_wdata_rdy = 1'b1;
        app_rdata_valid = 1'b0; app_rdata_end = 1'b0; app_rdata = '0;
        wbase = WBASE;
        for (int j = 0; j < 4; j++) rdat[j] = {4{32'(32'hA5A5_0000 + j)}};
        clr_mon();
        do_reset();

        // reset state
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_err", {127'd0, err_timeout}, 128'd0);
        chk("rst_addr", 128'(app_addr), 128'd0);
        chk("rst_rdv", {127'd0, rd_valid}, 128'd0);
        chk("rst_wrdone", {127'd0, wr_done}, 128'd0);

        // calibration gating, then a 4-beat write with the controller always ready
        clr_mon();
        req_valid = 1'b1; req_we = 1'b1; req_addr = '0; req_len = 6'd3;
        wd_valid = 1'b1;
        repeat (100) cyc();
        chk("gate_rdy", {127'd0, rdy_seen}, 128'd0);
        chk("gate_cmd", 128'(cmd_n), 128'd0);
        chk("gate_busy", {127'd0, busy}, 128'd0);
        init_calib_complete = 1'b1;
        cyc();
        req_valid = 1'b0;
        chk("gate_accept_rdy", {127'd0, rdy_seen}, 128'd1);
        chk("gate_accept_busy", {127'd0, busy}, 128'd1);
        wait_done(30, "wr4_done_seen");
        repeat (3) cyc();
        wd_valid = 1'b0;
        chk("wr4_cmd_n", 128'(cmd_n), 128'd1);
        chk("wr4_cmd", 128'(last_cmd), 128'd0);
        chk("wr4_burst", 128'(last_burst), 128'd3);
        chk("wr4_addr", 128'(last_addr), 128'd0);
        chk("wr4_beats", 128'(wr_n), 128'd4);
        for (int k = 0; k < 4; k++) chk("wr4_data", wr_log[k], WBASE + 128'(k));
        chk("wr4_done_n", 128'(done_n), 128'd1);
        chk("wr4_rdy_at_done", {127'd0, rdy_at_done}, 128'd0);
        chk("wr4_busy_end", {127'd0, busy}, 128'd0);

        // write with command stall and toggling data ready
        wbase = ~WBASE;
        clr_mon();
        wd_valid = 1'b1;
        app_cmd_rdy = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 28'hABCDEF0; req_len = 6'd3;
        cyc();
        req_valid = 1'b0;
        for (int i = 0; i < 40 && done_n == 0; i++) begin
            app_cmd_rdy   = (i >= 5);
            app_wdata_rdy = (i % 2 == 0);
            cyc();
        end
        app_cmd_rdy = 1'b1; app_wdata_rdy = 1'b1;
        chk("wrs_done_seen", 128'(done_n), 128'd1);
        repeat (2) cyc();
        wd_valid = 1'b0;
        chk("wrs_cmd_n", 128'(cmd_n), 128'd1);
        chk("wrs_addr", 128'(last_addr), 128'hABCDEF0);
        chk("wrs_beats", 128'(wr_n), 128'd4);
        for (int k = 0; k < 4; k++) chk("wrs_data", wr_log[k], ~WBASE + 128'(k));
        chk("wrs_done_cmd", 128'(done_cmd_n), 128'd1);
        chk("wrs_done_beats", 128'(done_wr_n), 128'd4);
        chk("wrs_done_n", 128'(done_n), 128'd1);

        // stray read data in IDLE, then a gapped 4-beat read
        clr_mon();
        lat_on = 1'b1;
        app_rdata_valid = 1'b1; app_rdata = 128'hDEAD;
        cyc();
        app_rdata_valid = 1'b0;
        cyc();
        chk("stray_rd", 128'(rd_n), 128'd0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 28'h1234567; req_len = 6'd3;
        cyc();
        req_valid = 1'b0;
        app_rdata_valid = 1'b1; app_rdata = 128'hBAD;
        cyc();
        for (int j = 0; j < 4; j++) begin
            app_rdata_valid = 1'b0; rd_armed = 1'b0;
            cyc();
            app_rdata_valid = 1'b1; app_rdata = rdat[j]; rd_armed = 1'b1;
            cyc();
        end
        app_rdata_valid = 1'b0; rd_armed = 1'b0;
        cyc();
        cyc();
        lat_on = 1'b0;
        chk("rd4_cmd_n", 128'(cmd_n), 128'd1);
        chk("rd4_cmd", 128'(last_cmd), 128'd1);
        chk("rd4_burst", 128'(last_burst), 128'd3);
        chk("rd4_addr", 128'(last_addr), 128'h1234567);
        chk("rd4_beats", 128'(rd_n), 128'd4);
        for (int j = 0; j < 4; j++) chk("rd4_data", rd_log[j], rdat[j]);
        chk("rd4_last", 128'(rd_last_log[3:0]), 128'b1000);
        chk("rd4_busy_end", {127'd0, busy}, 128'd0);

        // timeout: read command accepted, controller never returns data
        clr_mon();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 28'h20; req_len = 6'd0;
        cyc();
        req_valid = 1'b0;
        cyc();
        chk("tmo_cmd_n", 128'(cmd_n), 128'd1);
        repeat (TMO - 1) cyc();
        chk("tmo_err_early", {127'd0, err_timeout}, 128'd0);
        chk("tmo_busy_early", {127'd0, busy}, 128'd1);
        cyc();
        chk("tmo_err", {127'd0, err_timeout}, 128'd1);
        chk("tmo_busy", {127'd0, busy}, 128'd0);
        rdy_seen = 1'b0;
        req_valid = 1'b1;
        repeat (5) cyc();
        req_valid = 1'b0;
        chk("tmo_locked_rdy", {127'd0, rdy_seen}, 128'd0);
        chk("tmo_locked_cmd", 128'(cmd_n), 128'd1);
        chk("tmo_no_rd", 128'(rd_n), 128'd0);
        do_reset();
        chk("tmo_rst_err", {127'd0, err_timeout}, 128'd0);
        chk("tmo_rst_rdy", {127'd0, req_ready}, 128'd1);

        // reset after 2 of 4 write beats, then a normal 2-beat write
        wbase = 128'h1111_0000;
        clr_mon();
        wd_valid = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 28'h5A5A5A5; req_len = 6'd3;
        cyc();
        req_valid = 1'b0;
        cyc();
        cyc();
        chk("mid_beats", 128'(wr_n), 128'd2);
        wd_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_busy", {127'd0, busy}, 128'd0);
        chk("mid_addr", 128'(app_addr), 128'd0);
        chk("mid_cmd", 128'(app_cmd), 128'd0);
        chk("mid_burst", 128'(app_burst_number), 128'd0);
        chk("mid_wrdone", {127'd0, wr_done}, 128'd0);
        chk("mid_rdv", {127'd0, rd_valid}, 128'd0);
        repeat (3) cyc();
        chk("mid_no_done", 128'(done_n), 128'd0);
        wbase = 128'h2222_0000;
        clr_mon();
        wd_valid = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 28'h40; req_len = 6'd1;
        cyc();
        req_valid = 1'b0;
        wait_done(20, "post_done_seen");
        wd_valid = 1'b0;
        cyc();
        chk("post_beats", 128'(wr_n), 128'd2);
        chk("post_data0", wr_log[0], 128'h2222_0000);
        chk("post_data1", wr_log[1], 128'h2222_0001);
        chk("post_burst", 128'(last_burst), 128'd1);
        chk("post_addr", 128'(last_addr), 128'h40);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
